// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - write/read pointer, occupancy and ack/err strobe control for the register-file FIFO
// Optional almost_full/almost_empty outputs are enabled by defining FIFO_ALMOST_FLAGS_EN.
module fifo_ptr_ctrl #(
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [(1<<ADDR_W)-1:0]   we_onehot,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [ADDR_W:0]          data_count,
  output logic                     full,
  output logic                     empty,
`ifdef FIFO_ALMOST_FLAGS_EN
  output logic                     almost_full,
  output logic                     almost_empty,
`endif
  output logic                     wr_ack,
  output logic                     wr_err,
  output logic                     rd_ack,
  output logic                     rd_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WR_ERROR,
    READ,
    RD_ERROR,
    RW,
    W_RDERR,
    R_WRERR
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W:0]    count;
  logic               wr_ok;
  logic               rd_ok;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign wr_ok      = wr_en & ~full;
  assign rd_ok      = rd_en & ~empty;
  assign rd_addr    = rd_ptr;
  assign data_count = count;

`ifdef FIFO_ALMOST_FLAGS_EN
  assign almost_full  = (count >= FULL_CNT - 1'b1);
  assign almost_empty = (count <= (ADDR_W+1)'(1));
`endif

  // Gated by reset_n so an in-flight enable drops the moment reset asserts.
  always_comb begin
    we_onehot = '0;
    if (wr_ok && reset_n)
      we_onehot[wr_ptr] = 1'b1;
  end

  always_comb begin
    state_nxt = IDLE;
    case ({wr_en, rd_en})
      2'b11:   state_nxt = full ? R_WRERR : (empty ? W_RDERR : RW);
      2'b10:   state_nxt = full ? WR_ERROR : WRITE;
      2'b01:   state_nxt = empty ? RD_ERROR : READ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Strobes are registered from the next state so they follow the request by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      rd_ack <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_ack <= (state_nxt == WRITE) || (state_nxt == RW) || (state_nxt == W_RDERR);
      wr_err <= (state_nxt == WR_ERROR) || (state_nxt == R_WRERR);
      rd_ack <= (state_nxt == READ) || (state_nxt == RW) || (state_nxt == R_WRERR);
      rd_err <= (state_nxt == RD_ERROR) || (state_nxt == W_RDERR);
    end
  end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb/tb_fifo_ptr_ctrl.sv - directed-vector bench for fifo_ptr_ctrl at ADDR_W=3
module tb_fifo_ptr_ctrl;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] we_onehot;
  logic [2:0] rd_addr;
  logic [3:0] data_count;
  logic       full;
  logic       empty;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic       almost_full;
  logic       almost_empty;
`endif
  logic       wr_ack;
  logic       wr_err;
  logic       rd_ack;
  logic       rd_err;

  int total = 0;
  int bad   = 0;

  fifo_ptr_ctrl #(.ADDR_W(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .we_onehot  (we_onehot),
    .rd_addr    (rd_addr),
    .data_count (data_count),
    .full       (full),
    .empty      (empty),
`ifdef FIFO_ALMOST_FLAGS_EN
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`endif
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; strobes exp_str = {wr_ack, wr_err, rd_ack, rd_err}.
  task automatic do_op(input string tag, input logic w, input logic r,
                       input logic [7:0] exp_we, input logic [2:0] exp_ra,
                       input logic [3:0] exp_cnt, input logic [3:0] exp_str);
    wr_en = w;
    rd_en = r;
    #1;
    check({tag, "_we"}, we_onehot, exp_we);
    check({tag, "_ra"}, rd_addr, exp_ra);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_cnt"}, data_count, exp_cnt);
    check({tag, "_full"}, full, exp_cnt == 4'd8);
    check({tag, "_empty"}, empty, exp_cnt == 4'd0);
    check({tag, "_str"}, {wr_ack, wr_err, rd_ack, rd_err}, exp_str);
`ifdef FIFO_ALMOST_FLAGS_EN
    check({tag, "_afull"}, almost_full, exp_cnt >= 4'd7);
    check({tag, "_aempty"}, almost_empty, exp_cnt <= 4'd1);
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"}, we_onehot, 8'h00);
    check({tag, "_cnt"}, data_count, 4'd0);
    check({tag, "_empty"}, empty, 1'b1);
    check({tag, "_full"}, full, 1'b0);
    check({tag, "_ra"}, rd_addr, 3'd0);
    check({tag, "_str"}, {wr_ack, wr_err, rd_ack, rd_err}, 4'b0000);
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b1;
    rd_en   = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst_hold");

    // Release with wr_en still high: first edge writes entry 0.
    reset_n = 1'b1;
    do_op("rst_wr", 1, 0, 8'h01, 3'd0, 4'd1, 4'b1000);

    // Mid-cycle async reset with a write pending at entry 1.
    wr_en = 1'b1;
    #1;
    check("pre_rst_we", we_onehot, 8'h02);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk);
    wr_en   = 1'b0;
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++)
      do_op($sformatf("fill%0d", i), 1, 0, 8'(1 << i), 3'd0, 4'(i + 1), 4'b1000);
    do_op("fill_ovf", 1, 0, 8'h00, 3'd0, 4'd8, 4'b0100);

    for (int i = 0; i < 8; i++)
      do_op($sformatf("drain%0d", i), 0, 1, 8'h00, 3'(i), 4'(7 - i), 4'b0010);
    do_op("drain_udf", 0, 1, 8'h00, 3'd0, 4'd0, 4'b0001);

    // Wrap: pointers start at 0.
    for (int i = 0; i < 5; i++)
      do_op($sformatf("wrap_w%0d", i), 1, 0, 8'(1 << i), 3'd0, 4'(i + 1), 4'b1000);
    for (int i = 0; i < 5; i++)
      do_op($sformatf("wrap_r%0d", i), 0, 1, 8'h00, 3'(i), 4'(4 - i), 4'b0010);
    for (int i = 0; i < 6; i++)
      do_op($sformatf("wrap_w2_%0d", i), 1, 0, 8'(1 << ((5 + i) % 8)), 3'd5, 4'(i + 1), 4'b1000);

    // wr_ptr=3, rd_ptr=5, count=6; read down to 3.
    for (int i = 0; i < 3; i++)
      do_op($sformatf("to3_r%0d", i), 0, 1, 8'h00, 3'(5 + i), 4'(5 - i), 4'b0010);
    do_op("rw_mid", 1, 1, 8'h08, 3'd0, 4'd3, 4'b1010);

    // wr_ptr=4, rd_ptr=1; fill to 8.
    for (int i = 0; i < 5; i++)
      do_op($sformatf("tofull_w%0d", i), 1, 0, 8'(1 << ((4 + i) % 8)), 3'd1, 4'(4 + i), 4'b1000);
    do_op("rw_full", 1, 1, 8'h00, 3'd1, 4'd7, 4'b0110);

    // rd_ptr=2, count=7; drain to empty.
    for (int i = 0; i < 7; i++)
      do_op($sformatf("toempty_r%0d", i), 0, 1, 8'h00, 3'((2 + i) % 8), 4'(6 - i), 4'b0010);
    do_op("rw_empty", 1, 1, 8'h02, 3'd1, 4'd1, 4'b1001);
    do_op("idle", 0, 0, 8'h00, 3'd1, 4'd1, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
